regfile_dump: RTL and testbench



---
 rtl/regfile_dump.sv | 135 +++++++++++++
 tb/tb_regfile_dump.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks every regfile address through one read port and
// streams each word out over valid/ready with index, last flag and XOR checksum.
module regfile_dump #(
    parameter int SIZE   = 32,
    parameter int BITS   = $clog2(SIZE),
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [BITS-1:0]   rf_address,
    input  logic [WORD_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [BITS-1:0]   out_index,
    output logic              out_last,
    output logic [WORD_W-1:0] checksum
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        SEND    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [BITS-1:0] LAST_ADDR = BITS'(SIZE - 1);

    state_t state;
    state_t state_nxt;

    logic xfer;

    assign xfer = out_valid && out_ready;

    // State register; reset aborts any dump in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one word costs FETCH, CAPTURE and at least one SEND cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = SEND;
            end
            SEND: begin
                if (xfer) begin
                    state_nxt = out_last ? DONE : FETCH;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Status outputs decode straight from state, so they clear with reset.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Datapath: address walk, word capture, handshake and running checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_address <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            checksum   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rf_address <= '0;
                        checksum   <= '0;
                    end
                end
                CAPTURE: begin
                    out_data  <= rf_data;
                    out_index <= rf_address;
                    out_last  <= (rf_address == LAST_ADDR);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    if (xfer) begin
                        checksum  <= checksum ^ out_data;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (!out_last) begin
                            rf_address <= rf_address + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed checks of regfile_dump against a registered
// read-port regfile model with hand-computed expectations.
module tb_regfile_dump;

    localparam int SIZE = 32;
    localparam int BITS = 5;

    logic            clk;
    logic            reset;
    logic            start;
    logic            busy;
    logic            done;
    logic [BITS-1:0] rf_address;
    logic [31:0]     rf_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_data;
    logic [BITS-1:0] out_index;
    logic            out_last;
    logic [31:0]     checksum;

    logic [31:0] rf [SIZE];

    int n_asserts = 0;
    int n_fails   = 0;

    regfile_dump #(.SIZE(SIZE), .BITS(BITS), .WORD_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rf_address (rf_address),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read port, like the real regfile.
    always @(posedge clk) rf_data <= rf[rf_address];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // c counts posedges after the start-sampling edge; sampled at negedge.
    task automatic run_dump(input int stall_idx, input int stall_n,
                            input int poke_idx, input int exp_done_at,
                            input logic [31:0] exp_sum);
        int c;
        int nxt;
        int dcnt;
        int done_at;
        int left;
        int fv;
        logic poked;
        logic [31:0] sd;
        logic [31:0] si;
        nxt = 0; dcnt = 0; done_at = -1; left = stall_n; fv = -1;
        poked = 1'b0; sd = '0; si = '0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c = 0;
        while (c < 500) begin
            start = 1'b0;
            if (out_valid && fv < 0) fv = c;
            if (done) begin
                dcnt++;
                if (done_at < 0) done_at = c;
                chk("busy_at_done", {31'd0, busy}, 32'd1);
            end
            if (done_at >= 0 && c == done_at + 1) begin
                chk("busy_fall", {31'd0, busy}, 32'd0);
                break;
            end
            if (out_valid && !poked && int'(out_index) == poke_idx) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (out_valid && int'(out_index) == stall_idx && left > 0) begin
                if (left == stall_n) begin
                    sd = out_data;
                    si = {27'd0, out_index};
                end else begin
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_data", out_data, sd);
                    chk("stall_index", {27'd0, out_index}, si);
                end
                out_ready = 1'b0;
                left--;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                chk("xfer_index", {27'd0, out_index}, nxt);
                chk("xfer_data", out_data, rf[nxt]);
                chk("xfer_last", {31'd0, out_last}, (nxt == SIZE - 1) ? 1 : 0);
                nxt++;
            end
            @(posedge clk);
            c++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        start = 1'b0;
        chk("first_valid_cycle", fv, 32'd2);
        chk("done_cycle", done_at, exp_done_at);
        chk("done_pulses", dcnt, 32'd1);
        chk("transfers", nxt, SIZE);
        chk("checksum", checksum, exp_sum);
    endtask

    initial begin : stim
        int k;
        int dc;
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < SIZE; i++) rf[i] = 32'(i);

        // Reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_last", {31'd0, out_last}, 32'd0);
        chk("rst_addr", {27'd0, rf_address}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_index", {27'd0, out_index}, 32'd0);
        chk("rst_sum", checksum, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Full dump, rf[i] = i: XOR of 0..31 is 0
        run_dump(-1, 0, -1, 96, 32'h0);

        // Single nonzero word
        for (int i = 0; i < SIZE; i++) rf[i] = 32'h0;
        rf[5] = 32'hDEADBEEF;
        run_dump(-1, 0, -1, 96, 32'hDEADBEEF);
        repeat (10) @(negedge clk);
        chk("sum_held", checksum, 32'hDEADBEEF);
        chk("idle_after", {31'd0, busy}, 32'd0);

        // Backpressure: 4 stall cycles on index 7
        for (int i = 0; i < SIZE; i++) rf[i] = 32'(i);
        run_dump(7, 4, -1, 100, 32'h0);

        // Start pulse while busy at index 10
        run_dump(-1, 0, 10, 96, 32'h0);

        // Reset in SEND at index 12; rf[i] = i+1, words 1..12 XOR to 12
        for (int i = 0; i < SIZE; i++) rf[i] = 32'(i + 1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(out_valid && out_index == 5'd12) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reach_idx12", {31'd0, out_valid}, 32'd1);
        chk("sum_before_rst", checksum, 32'd12);
        #2 reset = 1'b0;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", checksum, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_addr", {27'd0, rf_address}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dc = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("abort_no_done", dc, 32'd0);
        // XOR of 1..32 is 32
        run_dump(-1, 0, -1, 96, 32'h20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule
